// File: rtl/rpc2_ctrl_adr_pkg.sv
// Shared definitions for the ADR command path: payload layout and direction tag.
package rpc2_ctrl_adr_pkg;

  // Pre-formatted command payload {size, burst, len, addr}
  localparam int PRE_ADR_DATA_WIDTH = 46;
  localparam int ADR_ADDR_LSB       = 0;
  localparam int ADR_ADDR_W         = 32;
  localparam int ADR_LEN_LSB        = 32;
  localparam int ADR_LEN_W          = 8;
  localparam int ADR_BURST_LSB      = 40;
  localparam int ADR_BURST_W        = 2;
  localparam int ADR_SIZE_LSB       = 42;
  localparam int ADR_SIZE_W         = 4;

  // Arbitrated command {is_write, block, payload}
  localparam int ADR_DOUT_WIDTH = PRE_ADR_DATA_WIDTH + 2;

  // Direction tag carried in the top bit of the arbitrated command
  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

endpackage

// File: rtl/rpc2_ctrl_credit_counter.sv
// Outstanding-transaction credit counter: +1 per grant, -1 per done pulse,
// with a sticky error when a done arrives and nothing is outstanding.
module rpc2_ctrl_credit_counter #(
  parameter int CNT_WIDTH = 3,
  parameter int MAX_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 below_limit,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  // Eligibility uses the registered count, so a done in the same cycle
  // only frees the slot from the next cycle on.
  assign below_limit = (count < LIMIT);

  // Count update; an underflowing done keeps the count and flags the error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      err   <= 1'b0;
    end else if (dec && (count == '0)) begin
      err   <= 1'b1;
      count <= inc ? ONE : '0;
    end else if (inc && !dec) begin
      count <= count + ONE;
    end else if (dec && !inc) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/rpc2_ctrl_axi_adr_arbiter.sv
// Weighted round-robin arbiter merging AW and AR commands into one registered
// ADR stream, gated by per-direction outstanding credits.
//
// Handshake: a source command is taken in the cycle its *_ready is high
// (ready is the grant itself, combinational, and never waits on the other
// source). The output slot holds adr_dout stable while adr_valid=1 and
// adr_ready=0; a new command may be granted into the slot whenever it is
// empty or being drained in the same cycle.
module rpc2_ctrl_axi_adr_arbiter
  import rpc2_ctrl_adr_pkg::*;
#(
  parameter int C_PRE_ADR_DATA_WIDTH = PRE_ADR_DATA_WIDTH,
  parameter int C_MAX_WR_OUTSTANDING = 4,
  parameter int C_MAX_RD_OUTSTANDING = 4,
  parameter int C_WR_WEIGHT          = 2,
  parameter int C_RD_WEIGHT          = 2,
  parameter int C_CNT_WIDTH          = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              adr_aw_valid,
  input  logic [C_PRE_ADR_DATA_WIDTH-1:0]   adr_aw_din,
  input  logic                              adr_aw_block,
  output logic                              adr_aw_ready,
  input  logic                              adr_ar_valid,
  input  logic [C_PRE_ADR_DATA_WIDTH-1:0]   adr_ar_din,
  input  logic                              adr_ar_block,
  output logic                              adr_ar_ready,
  output logic                              adr_valid,
  output logic [C_PRE_ADR_DATA_WIDTH+1:0]   adr_dout,
  input  logic                              adr_ready,
  input  logic                              wr_done,
  input  logic                              rd_done,
  output logic [C_CNT_WIDTH-1:0]            wr_outstanding,
  output logic [C_CNT_WIDTH-1:0]            rd_outstanding,
  output logic                              credit_err
);

  localparam logic [7:0] WR_W = 8'(C_WR_WEIGHT);
  localparam logic [7:0] RD_W = 8'(C_RD_WEIGHT);

  // Arbitration history, kept as one struct so it can be probed as a whole
  typedef struct packed {
    dir_e       last_dir;
    logic [7:0] streak;
  } arb_state_t;

  arb_state_t arb_q;

  logic       slot_free;
  logic       wr_below, rd_below;
  logic       wr_elig, rd_elig;
  logic       grant_wr, grant_rd, grant_any;
  logic       keep_streak;
  logic [7:0] last_weight, grant_weight;
  logic       wr_err, rd_err;

  assign slot_free = ~adr_valid | adr_ready;
  assign wr_elig   = adr_aw_valid & wr_below;
  assign rd_elig   = adr_ar_valid & rd_below;

  // A streak of 0 only exists straight after reset and means "no history";
  // the other-direction rule then applies, so writes win the first contest.
  assign last_weight = (arb_q.last_dir == DIR_WR) ? WR_W : RD_W;
  assign keep_streak = (arb_q.streak != 8'd0) && (arb_q.streak < last_weight);

  // Grant selection: single eligible source wins, contested slots use the weights
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (reset_n && slot_free) begin
      if (wr_elig && rd_elig) begin
        if (keep_streak) grant_wr = (arb_q.last_dir == DIR_WR);
        else             grant_wr = (arb_q.last_dir == DIR_RD);
        grant_rd = ~grant_wr;
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
  end

  assign grant_any    = grant_wr | grant_rd;
  assign grant_weight = grant_wr ? WR_W : RD_W;
  assign adr_aw_ready = grant_wr;
  assign adr_ar_ready = grant_rd;

  // Streak bookkeeping: extend (saturating) on a repeat, restart on a switch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_q.last_dir <= DIR_RD;
      arb_q.streak   <= 8'd0;
    end else if (grant_any) begin
      if ((grant_wr ? DIR_WR : DIR_RD) == arb_q.last_dir) begin
        if (arb_q.streak < grant_weight) arb_q.streak <= arb_q.streak + 8'd1;
      end else begin
        arb_q.last_dir <= grant_wr ? DIR_WR : DIR_RD;
        arb_q.streak   <= 8'd1;
      end
    end
  end

  // Output slice: load on grant, empty when drained without a replacement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adr_valid <= 1'b0;
      adr_dout  <= '0;
    end else if (grant_any) begin
      adr_valid <= 1'b1;
      adr_dout  <= grant_wr ? {logic'(DIR_WR), adr_aw_block, adr_aw_din}
                            : {logic'(DIR_RD), adr_ar_block, adr_ar_din};
    end else if (slot_free) begin
      adr_valid <= 1'b0;
    end
  end

  rpc2_ctrl_credit_counter #(
    .CNT_WIDTH (C_CNT_WIDTH),
    .MAX_COUNT (C_MAX_WR_OUTSTANDING)
  ) u_wr_credit (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc         (grant_wr),
    .dec         (wr_done),
    .count       (wr_outstanding),
    .below_limit (wr_below),
    .err         (wr_err)
  );

  rpc2_ctrl_credit_counter #(
    .CNT_WIDTH (C_CNT_WIDTH),
    .MAX_COUNT (C_MAX_RD_OUTSTANDING)
  ) u_rd_credit (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc         (grant_rd),
    .dec         (rd_done),
    .count       (rd_outstanding),
    .below_limit (rd_below),
    .err         (rd_err)
  );

  assign credit_err = wr_err | rd_err;

endmodule

// File: tb/tb_rpc2_ctrl_axi_adr_arbiter.sv
// Bench for the ADR arbiter: vector table, directed corner sequences and a
// randomized run, all checked against a behavioural model and an expected queue.
module tb_rpc2_ctrl_axi_adr_arbiter;
  import rpc2_ctrl_adr_pkg::*;

  localparam int DW   = 46;
  localparam int MAXW = 4;
  localparam int MAXR = 4;
  localparam int WRW  = 2;
  localparam int RDW  = 2;
  localparam int CW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          adr_aw_valid = 0, adr_aw_block = 0, adr_aw_ready;
  logic [DW-1:0] adr_aw_din = '0;
  logic          adr_ar_valid = 0, adr_ar_block = 0, adr_ar_ready;
  logic [DW-1:0] adr_ar_din = '0;
  logic          adr_valid, adr_ready = 0;
  logic [DW+1:0] adr_dout;
  logic          wr_done = 0, rd_done = 0;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic          credit_err;

  rpc2_ctrl_axi_adr_arbiter #(
    .C_PRE_ADR_DATA_WIDTH (DW),
    .C_MAX_WR_OUTSTANDING (MAXW),
    .C_MAX_RD_OUTSTANDING (MAXR),
    .C_WR_WEIGHT          (WRW),
    .C_RD_WEIGHT          (RDW),
    .C_CNT_WIDTH          (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .adr_aw_valid   (adr_aw_valid),
    .adr_aw_din     (adr_aw_din),
    .adr_aw_block   (adr_aw_block),
    .adr_aw_ready   (adr_aw_ready),
    .adr_ar_valid   (adr_ar_valid),
    .adr_ar_din     (adr_ar_din),
    .adr_ar_block   (adr_ar_block),
    .adr_ar_ready   (adr_ar_ready),
    .adr_valid      (adr_valid),
    .adr_dout       (adr_dout),
    .adr_ready      (adr_ready),
    .wr_done        (wr_done),
    .rd_done        (rd_done),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .credit_err     (credit_err)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;
  logic [DW+1:0] exp_q[$];

  int m_wr, m_rd, m_streak;
  bit m_last;              // 1 = last grant was a write
  bit m_err, m_valid;
  bit s_awr, s_arr;        // readies seen in the last cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_streak = 0; m_last = 0;
    m_err = 0; m_valid = 0;
    exp_q.delete();
  endtask

  // Reference behaviour for one clock: decides the grant from the rules and
  // advances credits, history and the output slot.
  task automatic model_step(input bit awv, input bit arv, input bit rdy, input bit wd, input bit rdd,
                            input logic awb, input logic [DW-1:0] awd,
                            input logic arb, input logic [DW-1:0] ard,
                            output bit gw, output bit gr);
    bit slot, we, re, keep;
    int wgt;
    slot = !m_valid || rdy;
    we   = awv && (m_wr < MAXW);
    re   = arv && (m_rd < MAXR);
    gw = 0; gr = 0;
    if (slot) begin
      if (we && re) begin
        keep = (m_streak > 0) && (m_streak < (m_last ? WRW : RDW));
        gw = keep ? m_last : !m_last;
        gr = !gw;
      end else begin
        gw = we; gr = re;
      end
    end
    if (wd) begin if (m_wr == 0) m_err = 1; else m_wr--; end
    if (rdd) begin if (m_rd == 0) m_err = 1; else m_rd--; end
    if (gw) m_wr++;
    if (gr) m_rd++;
    if (gw || gr) begin
      wgt = gw ? WRW : RDW;
      if (gw == m_last) m_streak = (m_streak + 1 > wgt) ? wgt : m_streak + 1;
      else m_streak = 1;
      m_last  = gw;
      m_valid = 1;
      exp_q.push_back(gw ? {1'b1, awb, awd} : {1'b0, arb, ard});
    end else if (slot) begin
      m_valid = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, checks registered outputs, scoreboard and readies at
  // the falling edge, then steps the model. Returns at posedge + 1.
  task automatic run_cycle(input bit awv, input bit awb, input logic [DW-1:0] awd,
                           input bit arv, input bit arb, input logic [DW-1:0] ard,
                           input bit rdy, input bit wd, input bit rdd);
    bit gw, gr;
    adr_aw_valid = awv; adr_aw_block = awb; adr_aw_din = awd;
    adr_ar_valid = arv; adr_ar_block = arb; adr_ar_din = ard;
    adr_ready = rdy; wr_done = wd; rd_done = rdd;
    @(negedge clk);
    check("adr_valid", adr_valid, m_valid);
    check("wr_outstanding", wr_outstanding, m_wr);
    check("rd_outstanding", rd_outstanding, m_rd);
    check("credit_err", credit_err, m_err);
    if (adr_valid && adr_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_cmd", 1, 0);
      else check("adr_dout", adr_dout, exp_q.pop_front());
    end
    s_awr = adr_aw_ready;
    s_arr = adr_ar_ready;
    model_step(awv, arv, rdy, wd, rdd, awb, awd, arb, ard, gw, gr);
    check("adr_aw_ready", adr_aw_ready, gw);
    check("adr_ar_ready", adr_ar_ready, gr);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_payload();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    reset_n = 0;
    adr_aw_valid = 1; adr_ar_valid = 1; adr_ready = 1;
    wr_done = 0; rd_done = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_adr_valid", adr_valid, 0);
    check("rst_adr_dout", adr_dout, 0);
    check("rst_aw_ready", adr_aw_ready, 0);
    check("rst_ar_ready", adr_ar_ready, 0);
    check("rst_counts", {wr_outstanding, rd_outstanding}, 0);
    check("rst_credit_err", credit_err, 0);
    adr_aw_valid = 0; adr_ar_valid = 0; adr_ready = 0;
    reset_n = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst;
    bit awv; bit arv; bit rdy; bit wd; bit rdd;
    bit e_awr; bit e_arr; int e_wr; int e_rd;
  } vec_t;

  vec_t tab[14];

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] a;

    // credit limit: four writes fill the credits, a done frees one a cycle later
    tab[0]  = '{1, 1,0,1,0,0, 1,0, 0,0};
    tab[1]  = '{0, 1,0,1,0,0, 1,0, 1,0};
    tab[2]  = '{0, 1,0,1,0,0, 1,0, 2,0};
    tab[3]  = '{0, 1,0,1,0,0, 1,0, 3,0};
    tab[4]  = '{0, 1,0,1,0,0, 0,0, 4,0};
    tab[5]  = '{0, 1,0,1,1,0, 0,0, 4,0};
    tab[6]  = '{0, 1,0,1,0,0, 1,0, 3,0};
    tab[7]  = '{0, 0,0,1,0,0, 0,0, 4,0};
    // weighting 2/2 from reset: W,W,R,R,W,W with dones keeping credits low
    tab[8]  = '{1, 1,1,1,0,0, 1,0, 0,0};
    tab[9]  = '{0, 1,1,1,1,0, 1,0, 1,0};
    tab[10] = '{0, 1,1,1,1,0, 0,1, 1,0};
    tab[11] = '{0, 1,1,1,0,1, 0,1, 0,1};
    tab[12] = '{0, 1,1,1,0,1, 1,0, 0,1};
    tab[13] = '{0, 1,1,1,1,0, 1,0, 1,0};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tab[i].rst) do_reset();
      run_cycle(tab[i].awv, 1'($urandom_range(0, 1)), rnd_payload(),
                tab[i].arv, 1'($urandom_range(0, 1)), rnd_payload(),
                tab[i].rdy, tab[i].wd, tab[i].rdd);
      check($sformatf("tab%0d_aw_ready", i), s_awr, tab[i].e_awr);
      check($sformatf("tab%0d_ar_ready", i), s_arr, tab[i].e_arr);
    end

    // write-only burst: three back-to-back commands, tag and block propagate
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = DW'((i + 1) * 32'h100);
      run_cycle(1, 1'(i[0]), a, 0, 0, '0, 1, 0, 0);
      check("wo_valid", adr_valid, 1);
      check("wo_is_write", adr_dout[DW+1], 1);
      check("wo_block", adr_dout[DW], 1'(i[0]));
      check("wo_addr", adr_dout[31:0], (i + 1) * 32'h100);
    end
    run_cycle(0, 0, '0, 0, 0, '0, 1, 0, 0);
    check("wo_wr_outstanding", wr_outstanding, 3);

    // backpressure: command held stable, no grants until the sink accepts
    do_reset();
    run_cycle(1, 1, rnd_payload(), 0, 0, '0, 1, 0, 0);
    held = adr_dout[DW-1:0];
    for (int i = 0; i < 4; i++) begin
      run_cycle(1, 0, rnd_payload(), 1, 1, rnd_payload(), 0, 0, 0);
      check("bp_no_aw_ready", s_awr, 0);
      check("bp_no_ar_ready", s_arr, 0);
      check("bp_dout_stable", adr_dout[DW-1:0], held);
    end
    run_cycle(1, 0, rnd_payload(), 0, 0, '0, 1, 0, 0);
    check("bp_release_grant", s_awr, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_payload(),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_payload(),
                1'($urandom_range(0, 3) != 0),
                (m_wr > 0) && ($urandom_range(0, 2) == 0),
                (m_rd > 0) && ($urandom_range(0, 2) == 0));
    end

    // simultaneous grant and done at count 2, then a read done at count 0
    do_reset();
    run_cycle(1, 0, rnd_payload(), 0, 0, '0, 1, 0, 0);
    run_cycle(1, 0, rnd_payload(), 0, 0, '0, 1, 0, 0);
    check("gd_pre_count", wr_outstanding, 2);
    run_cycle(1, 0, rnd_payload(), 0, 0, '0, 1, 1, 0);
    check("gd_grant_seen", s_awr, 1);
    check("gd_count_held", wr_outstanding, 2);
    run_cycle(0, 0, '0, 0, 0, '0, 1, 0, 1);
    check("underflow_rd_count", rd_outstanding, 0);
    check("underflow_err", credit_err, 1);
    run_cycle(0, 0, '0, 0, 0, '0, 1, 0, 0);
    check("underflow_err_sticky", credit_err, 1);

    // reset in the middle of traffic with counts 3/2 and a held command
    do_reset();
    for (int i = 0; i < 5; i++)
      run_cycle(1, 0, rnd_payload(), 1, 1, rnd_payload(), 1, 0, 0);
    check("mid_pre_counts", {wr_outstanding, rd_outstanding}, {3'd3, 3'd2});
    check("mid_pre_valid", adr_valid, 1);
    #2;
    reset_n = 0;
    #1;
    check("mid_rst_valid", adr_valid, 0);
    check("mid_rst_dout", adr_dout, 0);
    check("mid_rst_counts", {wr_outstanding, rd_outstanding}, 0);
    check("mid_rst_readies", {adr_aw_ready, adr_ar_ready}, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    run_cycle(1, 0, rnd_payload(), 1, 0, rnd_payload(), 1, 0, 0);
    check("mid_restart_write", {s_awr, s_arr}, 2'b10);
    run_cycle(0, 0, '0, 0, 0, '0, 1, 0, 0);

    // nothing left undelivered except a command still parked in the slot
    check("sb_remaining", exp_q.size(), m_valid ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpc2_ctrl_axi_adr_arbiter.md
Name: rpc2_ctrl_axi_adr_arbiter

Overview:
Arbitrates pre-formatted write-address (AW) and read-address (AR) commands into the single ADR command stream that feeds the memory-side sequencer. Each winning command carries a direction tag and its interleave block. Uses weighted round-robin between the two sources. Enforces per-direction outstanding limits via grant/done credit counters. The output stage is a registered valid/ready slice.

Parameters:
C_PRE_ADR_DATA_WIDTH, 46, width of adr_aw_din/adr_ar_din ({size,burst,len,addr})
C_MAX_WR_OUTSTANDING, 4, max granted-but-not-done writes (1..2^C_CNT_WIDTH-1)
C_MAX_RD_OUTSTANDING, 4, max granted-but-not-done reads
C_WR_WEIGHT, 2, consecutive write grants allowed while a read is eligible (>=1)
C_RD_WEIGHT, 2, consecutive read grants allowed while a write is eligible (>=1)
C_CNT_WIDTH, 3, width of outstanding counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
adr_aw_valid  in  1  write command valid
adr_aw_din  in  C_PRE_ADR_DATA_WIDTH  write command payload
adr_aw_block  in  1  write interleave block (0/1)
adr_aw_ready  out  1  write command accepted this cycle (combinational)
adr_ar_valid  in  1  read command valid
adr_ar_din  in  C_PRE_ADR_DATA_WIDTH  read command payload
adr_ar_block  in  1  read interleave block
adr_ar_ready  out  1  read command accepted this cycle (combinational)
adr_valid  out  1  registered output command valid
adr_dout  out  C_PRE_ADR_DATA_WIDTH+2  {is_write, block, payload}
adr_ready  in  1  sequencer accepts adr_dout
wr_done  in  1  one write transaction retired (pulse)
rd_done  in  1  one read transaction retired (pulse)
wr_outstanding  out  C_CNT_WIDTH  current write credit count
rd_outstanding  out  C_CNT_WIDTH  current read credit count
credit_err  out  1  sticky: a done pulse arrived while its count was 0

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous active-low. Reset values: adr_valid=0, adr_dout=0, both counters=0, credit_err=0, last_dir=read, streak=0. Ready outputs are 0 during and after reset until the grant conditions hold. Reset mid-operation drops any held command and clears all credits.
- slot_free = ~adr_valid | adr_ready.
- wr_elig = adr_aw_valid & (wr_outstanding < C_MAX_WR_OUTSTANDING).
- rd_elig = adr_ar_valid & (rd_outstanding < C_MAX_RD_OUTSTANDING).
- Grant happens only when slot_free is high. At most one grant per cycle. adr_aw_ready / adr_ar_ready equal the respective grant; they never depend on the other source's ready.
- Arbitration when only one source is eligible: grant that source.
- Arbitration when both are eligible:
  - If last_dir=write and streak<C_WR_WEIGHT, grant write.
  - If last_dir=read and streak<C_RD_WEIGHT, grant read.
  - Otherwise grant the other direction.
- Streak update on grant: if the granted direction equals last_dir, streak+1 (saturating at max weight). Otherwise streak=1 and last_dir is updated. No grant: streak and last_dir hold.
- Output latency is one cycle. On grant, the next cycle has adr_valid=1 and adr_dout={dir, block, din}. If slot_free is high with no grant, adr_valid goes to 0. If adr_valid=1 and adr_ready=0, adr_dout is held stable (no grant possible).
- Credits:
  - wr_outstanding +1 on write grant, -1 on wr_done. Both in the same cycle leaves it unchanged. rd_outstanding follows the same rule.
  - A done pulse with count 0 leaves the count at 0 and sets credit_err (cleared only by reset).
  - The count never exceeds its MAX because grant is gated.
- Back-to-back: with adr_ready held 1, one command issues per cycle sustained.
- Counter at MAX with a done pulse in the same cycle: the grant is still blocked this cycle (comparison uses the registered count); the grant is allowed next cycle.

Decomposition:
- Shared package rpc2_ctrl_adr_pkg holds:
  - PRE_ADR_DATA_WIDTH and the ADR field offsets (addr[31:0], len, burst, size).
  - The direction-tag encoding: WR=1, RD=0.
- One natural sub-module is rpc2_ctrl_credit_counter (inc/dec/limit/err), instantiated twice. The arbiter and output register stay in the top.

Test Plan:
- Write-only: 3 AW commands (addr 0x100/0x200/0x300), adr_ready=1 -> adr_valid for 3 consecutive cycles, adr_dout[47]=1, block bits propagate, wr_outstanding=3.
- Weighting: both sources continuously valid, weights 2/2, no credit limits hit (done pulses each cycle) -> grant order W,W,R,R,W,W (last_dir=read at reset; first W starts a streak).
- Credit limit: 5 AW with no wr_done -> 4 grants, adr_aw_ready low thereafter. One wr_done -> 5th granted the following cycle. Counter reads 4,3,4.
- Backpressure: adr_ready=0 for 4 cycles with valid command held -> adr_dout stable, no ready pulses. Release -> next grant in the same cycle adr_ready rises.
- Simultaneous grant + done at count 2 -> count stays 2. rd_done at count 0 -> count stays 0, credit_err=1.
- Reset asserted mid-stream with adr_valid=1, counts 3/2 -> all outputs immediately 0. After release, arbitration restarts with write priority.
